// File: rtl/hnf_txreq_lcrd_pkg.sv
// Shared CHI TXREQ definitions: request flit layout, opcodes and link FSM encodings.
package hnf_txreq_lcrd_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] tgt_id;
    logic [10:0] src_id;
    logic [11:0] txn_id;
    logic [6:0]  opcode;
    logic [2:0]  size;
    logic [47:0] addr;
  } reqflit_t;

  localparam logic [6:0] OP_REQ_LCRD_RETURN = 7'h00;
  localparam logic [6:0] OP_READ_NO_SNP     = 7'h04;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // A credit-return flit carries only its opcode; every other field is zero.
  function automatic reqflit_t lcrd_return_flit();
    reqflit_t f;
    f        = '0;
    f.opcode = OP_REQ_LCRD_RETURN;
    return f;
  endfunction

endpackage

// File: rtl/hnf_txreq_lcrd_sync_fifo.sv
// Single-clock FIFO for request flits with full/empty flags and an occupancy count.
module sync_fifo
  import hnf_txreq_lcrd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  reqflit_t       push_data,
  input  logic           pop,
  output reqflit_t       pop_data,
  output logic           full,
  output logic           empty,
  output logic [AW:0]    count
);

  reqflit_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/hnf_txreq_lcrd.sv
// HN-F TXREQ link-layer transmit stage: buffers request flits, issues them against
// SN link credits, and returns all held credits on link deactivation.
module hnf_txreq_lcrd
  import hnf_txreq_lcrd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_CRD = 15,
  localparam int CRD_W  = $clog2(MAX_CRD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             txreq_in_valid,
  output logic             txreq_in_ready,
  input  reqflit_t         txreq_in,
  output reqflit_t         TXREQFLIT,
  output logic             TXREQFLITV,
  output logic             TXREQFLITPEND,
  input  logic             TXREQLCRDV,
  input  logic             link_deact_req,
  output logic             link_stopped,
  output logic [CRD_W-1:0] crd_cnt,
  output logic             crd_overflow
);

  localparam int FCW = $clog2(DEPTH) + 1;
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(MAX_CRD);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CRD_W-1:0] crd_next;
  logic             ovf_set;

  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  reqflit_t         fifo_head;

  logic             push;
  logic             has_crd;
  logic             issue_flit;
  logic             issue_ret;
  logic             issue;

  assign txreq_in_ready = !fifo_full && (state == ST_RUN) && !reset;
  assign push           = txreq_in_valid && txreq_in_ready;
  assign has_crd        = (crd_cnt != '0);

  assign issue_flit = ((state == ST_RUN) || (state == ST_DRAIN)) && !fifo_empty && has_crd;
  assign issue_ret  = (state == ST_RETURN) && has_crd;
  assign issue      = issue_flit || issue_ret;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (txreq_in),
    .pop       (issue_flit),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    crd_next = crd_cnt;
    ovf_set  = 1'b0;
    case ({TXREQLCRDV, issue})
      2'b10: begin
        if (crd_cnt == CRD_MAX) ovf_set  = 1'b1;
        else                    crd_next = crd_cnt + 1'b1;
      end
      2'b01:   crd_next = crd_cnt - 1'b1;
      default: crd_next = crd_cnt;
    endcase
  end

  // Deactivation always runs to STOP even if the request drops part-way.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (link_deact_req)                 state_next = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty && !issue)           state_next = ST_RETURN;
      ST_RETURN: if (!has_crd && !TXREQLCRDV)        state_next = ST_STOP;
      ST_STOP:   if (!link_deact_req)                state_next = ST_RUN;
      default:                                       state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_RUN;
      crd_cnt      <= '0;
      crd_overflow <= 1'b0;
      TXREQFLITV   <= 1'b0;
      TXREQFLIT    <= '0;
    end else begin
      state        <= state_next;
      crd_cnt      <= crd_next;
      crd_overflow <= crd_overflow | ovf_set;
      TXREQFLITV   <= issue;
      if (issue) TXREQFLIT <= issue_ret ? lcrd_return_flit() : fifo_head;
    end
  end

  assign link_stopped  = (state == ST_STOP);
  assign TXREQFLITPEND = (state != ST_STOP) &&
                         ((fifo_count != '0) || txreq_in_valid || (state == ST_RETURN));

endmodule

// File: tb/tb_hnf_txreq_lcrd.sv
// Scoreboard bench for hnf_txreq_lcrd: directed stimulus queues expected flits,
// a negedge monitor pops and compares each TXREQFLITV beat.
module tb_hnf_txreq_lcrd;
  import hnf_txreq_lcrd_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_CRD = 15;
  localparam int CRD_W   = $clog2(MAX_CRD + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             txreq_in_valid = 1'b0;
  logic             txreq_in_ready;
  reqflit_t         txreq_in = '0;
  reqflit_t         TXREQFLIT;
  logic             TXREQFLITV;
  logic             TXREQFLITPEND;
  logic             TXREQLCRDV = 1'b0;
  logic             link_deact_req = 1'b0;
  logic             link_stopped;
  logic [CRD_W-1:0] crd_cnt;
  logic             crd_overflow;

  hnf_txreq_lcrd #(.DEPTH(DEPTH), .MAX_CRD(MAX_CRD)) dut (
    .clock          (clock),
    .reset          (reset),
    .txreq_in_valid (txreq_in_valid),
    .txreq_in_ready (txreq_in_ready),
    .txreq_in       (txreq_in),
    .TXREQFLIT      (TXREQFLIT),
    .TXREQFLITV     (TXREQFLITV),
    .TXREQFLITPEND  (TXREQFLITPEND),
    .TXREQLCRDV     (TXREQLCRDV),
    .link_deact_req (link_deact_req),
    .link_stopped   (link_stopped),
    .crd_cnt        (crd_cnt),
    .crd_overflow   (crd_overflow)
  );

  always #5 clock = ~clock;

  int       n_checks = 0;
  int       n_errors = 0;
  int       cyc      = 0;
  int       seen     = 0;
  reqflit_t exp_q[$];
  int       flit_cyc[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every output beat must match the head of the expected queue.
  always @(negedge clock) begin
    if (TXREQFLITV === 1'b1) begin
      seen++;
      flit_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("flit_unexpected", 128'(exp_q.size()), 128'd1);
      else                   check("flit_data", TXREQFLIT, exp_q.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic reqflit_t mk(input logic [11:0] txn, input logic [47:0] addr);
    reqflit_t f;
    f        = '0;
    f.qos    = 4'h3;
    f.tgt_id = 11'h020;
    f.src_id = 11'h010;
    f.txn_id = txn;
    f.opcode = OP_READ_NO_SNP;
    f.size   = 3'd6;
    f.addr   = addr;
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer a flit for the coming edge; a transfer is recorded only if the handshake completes.
  task automatic present(input reqflit_t f, input logic exp_ready, input string name);
    txreq_in       = f;
    txreq_in_valid = 1'b1;
    check(name, txreq_in_ready, exp_ready);
    if (txreq_in_ready) exp_q.push_back(f);
  endtask

  task automatic grant(input int n);
    TXREQLCRDV = 1'b1;
    ticks(n);
    TXREQLCRDV = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    check("rst_ready", txreq_in_ready, 1'b0);
    check("rst_flitv", TXREQFLITV, 1'b0);
    check("rst_flit", TXREQFLIT, '0);
    check("rst_crd", crd_cnt, 0);
    check("rst_ovf", crd_overflow, 1'b0);
    check("rst_stopped", link_stopped, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", txreq_in_ready, 1'b1);
    check("post_rst_pend", TXREQFLITPEND, 1'b0);
  endtask

  int base;
  int acc;
  int g;
  int n;

  initial begin
    do_reset();

    // 3 credits, then A, B, C back to back
    grant(3);
    check("t1_crd3", crd_cnt, 3);
    base = flit_cyc.size();
    present(mk(12'h00A, 48'h1000), 1'b1, "t1_ready_a");
    tick();
    acc = cyc;
    present(mk(12'h00B, 48'h1040), 1'b1, "t1_ready_b");
    tick();
    present(mk(12'h00C, 48'h1080), 1'b1, "t1_ready_c");
    tick();
    txreq_in_valid = 1'b0;
    ticks(4);
    check("t1_count", flit_cyc.size() - base, 3);
    check("t1_latency", flit_cyc[base], acc + 1);
    check("t1_consec_b", flit_cyc[base+1], flit_cyc[base] + 1);
    check("t1_consec_c", flit_cyc[base+2], flit_cyc[base] + 2);
    check("t1_crd0", crd_cnt, 0);

    // No credits: flits wait, PEND stays high, one grant releases exactly one
    base = seen;
    present(mk(12'h00D, 48'h2000), 1'b1, "t2_ready_d");
    tick();
    present(mk(12'h00E, 48'h2040), 1'b1, "t2_ready_e");
    tick();
    txreq_in_valid = 1'b0;
    ticks(3);
    check("t2_no_flit", seen - base, 0);
    check("t2_pend", TXREQFLITPEND, 1'b1);
    check("t2_ready", txreq_in_ready, 1'b1);
    g = flit_cyc.size();
    TXREQLCRDV = 1'b1;
    tick();
    acc = cyc;
    TXREQLCRDV = 1'b0;
    ticks(4);
    check("t2_one_flit", seen - base, 1);
    check("t2_grant_latency", flit_cyc[g], acc + 1);
    check("t2_crd0", crd_cnt, 0);
    grant(1);
    ticks(3);
    check("t2_drained", seen - base, 2);
    check("t2_pend_idle", TXREQFLITPEND, 1'b0);

    // Streaming with a grant every cycle holds the count at 2
    grant(2);
    check("t3_crd2", crd_cnt, 2);
    base = flit_cyc.size();
    present(mk(12'h00F, 48'h3000), 1'b1, "t3_ready_f");
    tick();
    TXREQLCRDV = 1'b1;
    present(mk(12'h010, 48'h3040), 1'b1, "t3_ready_g");
    tick();
    check("t3_crd_g", crd_cnt, 2);
    present(mk(12'h011, 48'h3080), 1'b1, "t3_ready_h");
    tick();
    check("t3_crd_h", crd_cnt, 2);
    present(mk(12'h012, 48'h30C0), 1'b1, "t3_ready_i");
    tick();
    check("t3_crd_i", crd_cnt, 2);
    txreq_in_valid = 1'b0;
    tick();
    check("t3_crd_end", crd_cnt, 2);
    TXREQLCRDV = 1'b0;
    ticks(3);
    check("t3_count", flit_cyc.size() - base, 4);
    check("t3_rate_1", flit_cyc[base+1], flit_cyc[base] + 1);
    check("t3_rate_3", flit_cyc[base+3], flit_cyc[base] + 3);
    check("t3_crd_hold", crd_cnt, 2);

    // Reset mid-operation discards held credits
    do_reset();

    // Fill FIFO with no credits; the fifth offer is held upstream
    base = seen;
    present(mk(12'h020, 48'h4000), 1'b1, "t4_ready_j");
    tick();
    present(mk(12'h021, 48'h4040), 1'b1, "t4_ready_k");
    tick();
    present(mk(12'h022, 48'h4080), 1'b1, "t4_ready_l");
    tick();
    present(mk(12'h023, 48'h40C0), 1'b1, "t4_ready_m");
    tick();
    txreq_in       = mk(12'h024, 48'h4100);
    txreq_in_valid = 1'b1;
    check("t4_full_0", txreq_in_ready, 1'b0);
    tick();
    check("t4_full_1", txreq_in_ready, 1'b0);
    tick();
    check("t4_full_2", txreq_in_ready, 1'b0);
    check("t4_pend", TXREQFLITPEND, 1'b1);
    check("t4_no_flit", seen - base, 0);
    grant(1);
    n = 0;
    while (!txreq_in_ready && n < 20) begin
      tick();
      n++;
    end
    present(mk(12'h024, 48'h4100), 1'b1, "t4_ready_n");
    tick();
    txreq_in_valid = 1'b0;
    grant(4);
    ticks(6);
    check("t4_all_out", seen - base, 5);
    check("t4_crd0", crd_cnt, 0);
    check("t4_pend_idle", TXREQFLITPEND, 1'b0);

    // Deactivation: 2 buffered flits, 5 credits granted, then 3 credit returns
    base = seen;
    present(mk(12'h030, 48'h5000), 1'b1, "t5_ready_p");
    tick();
    present(mk(12'h031, 48'h5040), 1'b1, "t5_ready_q");
    tick();
    txreq_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(lcrd_return_flit());
    link_deact_req = 1'b1;
    TXREQLCRDV     = 1'b1;
    tick();
    check("t5_drain_ready", txreq_in_ready, 1'b0);
    ticks(4);
    TXREQLCRDV = 1'b0;
    n = 0;
    while (!link_stopped && n < 30) begin
      tick();
      n++;
    end
    check("t5_stopped", link_stopped, 1'b1);
    check("t5_crd0", crd_cnt, 0);
    check("t5_flits", seen - base, 5);
    check("t5_stop_ready", txreq_in_ready, 1'b0);
    check("t5_stop_pend", TXREQFLITPEND, 1'b0);
    link_deact_req = 1'b0;
    tick();
    check("t5_run_stopped", link_stopped, 1'b0);
    check("t5_run_ready", txreq_in_ready, 1'b1);

    // Credit saturation and sticky overflow
    grant(MAX_CRD);
    check("t6_crd_max", crd_cnt, MAX_CRD);
    check("t6_no_ovf", crd_overflow, 1'b0);
    grant(1);
    check("t6_crd_sat", crd_cnt, MAX_CRD);
    check("t6_ovf", crd_overflow, 1'b1);
    tick();
    check("t6_ovf_sticky", crd_overflow, 1'b1);
    do_reset();

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
